// File: rtl/sam_vid_addr_if.sv
// Video address bus between the VDG side (master) and the SAM video address generator (slave).
// Carries the mode/offset registers, the VDG timing strobes and the generated addresses.
interface sam_vid_addr_if;
    logic [2:0]  mode;
    logic [6:0]  disp_offset;
    logic        da0;
    logic        hs_n;
    logic        fs_n;
    logic [15:0] vaddr;
    logic [15:0] row_base;
    logic [3:0]  line_cnt;

    modport master (
        output mode, disp_offset, da0, hs_n, fs_n,
        input  vaddr, row_base, line_cnt
    );

    modport slave (
        input  mode, disp_offset, da0, hs_n, fs_n,
        output vaddr, row_base, line_cnt
    );
endinterface

// File: rtl/sam_vid_addr.sv
// CoCo2 SAM video address counter: steps through display RAM on DA0, repeats scan
// lines per VDG mode on HS, and reloads from the display offset on FS.
module sam_vid_addr #(
    parameter int ALPHA_LINES = 12,
    parameter int ADDR_W      = 16
) (
    input  logic           clk,
    input  logic           reset,
    sam_vid_addr_if.slave  bus
);

    if (ALPHA_LINES < 1 || ALPHA_LINES > 16) begin : g_bad_alpha_lines
        $error("sam_vid_addr: ALPHA_LINES must be in 1..16");
    end
    if (ADDR_W != 16) begin : g_bad_addr_w
        $error("sam_vid_addr: ADDR_W must be 16");
    end

    localparam logic [3:0] ALPHA_M1 = 4'(ALPHA_LINES - 1);

    logic              da0_q, da0_d;
    logic              hs_q, hs_d;
    logic              fs_q, fs_d;
    logic              run_q, run_d;
    logic [ADDR_W-1:0] vaddr_q, vaddr_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [3:0]        line_cnt_q, line_cnt_d;

    logic       da0_fall, hs_fall, fs_fall;
    logic [3:0] ydiv_m1;

    assign da0_fall = da0_q & ~bus.da0;
    assign hs_fall  = hs_q & ~bus.hs_n;
    assign fs_fall  = fs_q & ~bus.fs_n;

    // Last scan line index of a row; mode 111 (DMA) behaves like 110.
    always_comb begin
        ydiv_m1 = 4'd0;
        case (bus.mode)
            3'b000:          ydiv_m1 = ALPHA_M1;
            3'b001, 3'b010:  ydiv_m1 = 4'd2;
            3'b011, 3'b100:  ydiv_m1 = 4'd1;
            default:         ydiv_m1 = 4'd0;
        endcase
    end

    // After reset the counter is parked at 0 until the first frame start arrives.
    always_comb begin
        da0_d      = bus.da0;
        hs_d       = bus.hs_n;
        fs_d       = bus.fs_n;
        run_d      = run_q;
        vaddr_d    = vaddr_q;
        row_base_d = row_base_q;
        line_cnt_d = line_cnt_q;
        if (fs_fall) begin
            run_d      = 1'b1;
            vaddr_d    = {bus.disp_offset, 9'b0};
            row_base_d = {bus.disp_offset, 9'b0};
            line_cnt_d = 4'd0;
        end else if (run_q && hs_fall) begin
            if (line_cnt_q >= ydiv_m1) begin
                row_base_d = vaddr_q;
                line_cnt_d = 4'd0;
            end else begin
                vaddr_d    = row_base_q;
                line_cnt_d = line_cnt_q + 4'd1;
            end
        end else if (run_q && da0_fall) begin
            vaddr_d = vaddr_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            da0_q      <= 1'b0;
            hs_q       <= 1'b1;
            fs_q       <= 1'b1;
            run_q      <= 1'b0;
            vaddr_q    <= '0;
            row_base_q <= '0;
            line_cnt_q <= 4'd0;
        end else begin
            da0_q      <= da0_d;
            hs_q       <= hs_d;
            fs_q       <= fs_d;
            run_q      <= run_d;
            vaddr_q    <= vaddr_d;
            row_base_q <= row_base_d;
            line_cnt_q <= line_cnt_d;
        end
    end

    assign bus.vaddr    = vaddr_q;
    assign bus.row_base = row_base_q;
    assign bus.line_cnt = line_cnt_q;

endmodule

// File: tb/tb_sam_vid_addr.sv
// Directed testbench for sam_vid_addr: inputs change on the falling clk edge and
// outputs are checked on the following falling edge, against hand-computed values.
module tb_sam_vid_addr;

    logic clk;
    logic reset;
    int   checks;
    int   passes;

    sam_vid_addr_if bus ();

    sam_vid_addr #(.ALPHA_LINES(12), .ADDR_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one set of VDG strobes and let one clk edge consume them.
    task automatic applyStimulus(input logic da0, input logic hs_n, input logic fs_n);
        bus.da0  = da0;
        bus.hs_n = hs_n;
        bus.fs_n = fs_n;
        @(negedge clk);
    endtask

    task automatic da0Pulses(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1);
            applyStimulus(1'b0, 1'b1, 1'b1);
        end
    endtask

    task automatic hsPulse();
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
    endtask

    task automatic fsPulse();
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        checks          = 0;
        passes          = 0;
        reset           = 1'b1;
        bus.mode        = 3'b000;
        bus.disp_offset = 7'h00;
        bus.da0         = 1'b0;
        bus.hs_n        = 1'b1;
        bus.fs_n        = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_vaddr",    32'(bus.vaddr),    32'h0000);
        checkOutput("reset_row_base", 32'(bus.row_base), 32'h0000);
        checkOutput("reset_line_cnt", 32'(bus.line_cnt), 32'd0);

        // Frame start loads the display offset, visible right after the first low sample.
        bus.disp_offset = 7'h02;
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("fs_vaddr",    32'(bus.vaddr),    32'h0400);
        checkOutput("fs_row_base", 32'(bus.row_base), 32'h0400);
        checkOutput("fs_line_cnt", 32'(bus.line_cnt), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1);

        da0Pulses(32);
        checkOutput("alpha_32_fetch", 32'(bus.vaddr), 32'h0420);
        hsPulse();
        checkOutput("alpha_rep_vaddr", 32'(bus.vaddr),    32'h0400);
        checkOutput("alpha_rep_line",  32'(bus.line_cnt), 32'd1);
        for (int l = 0; l < 10; l++) begin
            da0Pulses(32);
            hsPulse();
        end
        checkOutput("alpha_line11",       32'(bus.line_cnt), 32'd11);
        checkOutput("alpha_line11_vaddr", 32'(bus.vaddr),    32'h0400);
        da0Pulses(32);
        hsPulse();
        checkOutput("alpha_adv_row_base", 32'(bus.row_base), 32'h0420);
        checkOutput("alpha_adv_vaddr",    32'(bus.vaddr),    32'h0420);
        checkOutput("alpha_adv_line",     32'(bus.line_cnt), 32'd0);

        // Reset in mid-frame clears at once and holds until the next frame start.
        da0Pulses(3);
        checkOutput("pre_reset_vaddr", 32'(bus.vaddr), 32'h0423);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midframe_reset_vaddr", 32'(bus.vaddr), 32'h0000);
        reset = 1'b0;
        da0Pulses(2);
        checkOutput("post_reset_hold", 32'(bus.vaddr), 32'h0000);

        // Mode 101: no row repeat.
        bus.mode        = 3'b101;
        bus.disp_offset = 7'h00;
        fsPulse();
        checkOutput("m101_fs_vaddr", 32'(bus.vaddr), 32'h0000);
        da0Pulses(32);
        hsPulse();
        checkOutput("m101_row_base", 32'(bus.row_base), 32'h0020);
        checkOutput("m101_vaddr",    32'(bus.vaddr),    32'h0020);
        checkOutput("m101_line",     32'(bus.line_cnt), 32'd0);

        // Switch to alpha mode: this row now repeats.
        bus.mode = 3'b000;
        da0Pulses(32);
        hsPulse();
        checkOutput("m000_rep_vaddr", 32'(bus.vaddr),    32'h0020);
        checkOutput("m000_rep_line",  32'(bus.line_cnt), 32'd1);

        // Shrinking ydiv mid-row forces an advance on the next line end.
        bus.mode = 3'b011;
        da0Pulses(32);
        hsPulse();
        checkOutput("shrink_row_base", 32'(bus.row_base), 32'h0040);
        checkOutput("shrink_line",     32'(bus.line_cnt), 32'd0);
        bus.mode = 3'b001;
        hsPulse();
        checkOutput("m001_rep_line",  32'(bus.line_cnt), 32'd1);
        checkOutput("m001_rep_vaddr", 32'(bus.vaddr),    32'h0040);

        // Address wraps from 0xFFFF to 0x0000.
        bus.mode        = 3'b000;
        bus.disp_offset = 7'h7F;
        fsPulse();
        checkOutput("wrap_start", 32'(bus.vaddr), 32'hFE00);
        da0Pulses(511);
        checkOutput("wrap_ffff", 32'(bus.vaddr), 32'hFFFF);
        da0Pulses(1);
        checkOutput("wrap_0000", 32'(bus.vaddr), 32'h0000);

        // All three edges in one clk: frame start wins.
        bus.disp_offset = 7'h01;
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("prio_all_vaddr",    32'(bus.vaddr),    32'h0200);
        checkOutput("prio_all_row_base", 32'(bus.row_base), 32'h0200);
        checkOutput("prio_all_line",     32'(bus.line_cnt), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1);

        // Line end and fetch together on a repeat line: the increment is dropped.
        da0Pulses(2);
        checkOutput("prio_pre_vaddr", 32'(bus.vaddr), 32'h0202);
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("prio_hs_da0_vaddr", 32'(bus.vaddr),    32'h0200);
        checkOutput("prio_hs_da0_line",  32'(bus.line_cnt), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
